apb_addr_decoder: RTL

- Sits directly downstream of the cpu block's APB source port. Presents one APB target port to the cpu and fans it out to NUM_TGT APB initiator ports, one per peripheral region.
- Decodes a region index from a fixed address slice and runs the selected downstream transfer.
- Returns the response upstream, adding decode-error and timeout-error reporting plus a saturating error counter for debug.

---
 rtl/apb_addr_decoder_pkg.sv | 28 ++
 rtl/apb_addr_decoder_timeout_ctr.sv | 29 ++
 rtl/apb_addr_decoder.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/apb_addr_decoder_pkg.sv
// Shared types and constants for the APB region decoder: FSM states, default
// index-field placement and the base address of every peripheral region.
package apbDecode_package;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_M_SETUP  = 3'd1,
        ST_M_ACCESS = 3'd2,
        ST_RESP     = 3'd3,
        ST_DEC_ERR  = 3'd4
    } state_e;

    localparam int DEF_SEL_LSB = 12;
    localparam int DEF_SEL_W   = 4;

    // Region i occupies [i << DEF_SEL_LSB, (i+1) << DEF_SEL_LSB).
    localparam logic [31:0] REGION_BASE [16] = '{
        32'h0000_0000, 32'h0000_1000, 32'h0000_2000, 32'h0000_3000,
        32'h0000_4000, 32'h0000_5000, 32'h0000_6000, 32'h0000_7000,
        32'h0000_8000, 32'h0000_9000, 32'h0000_A000, 32'h0000_B000,
        32'h0000_C000, 32'h0000_D000, 32'h0000_E000, 32'h0000_F000
    };

    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/apb_addr_decoder_timeout_ctr.sv
// Loadable down-counter that flags expiry once it has counted down to zero.
module apb_timeout_ctr
    import apbDecode_package::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             expired
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - WIDTH'(1);
        end
    end

    assign expired = (count_reg == '0);

endmodule

// File: rtl/apb_addr_decoder.sv
// APB fan-out: decodes a region index from the upstream address, runs the
// transfer on the selected target and returns a registered one-cycle response.
module apb_addr_decoder
    import apbDecode_package::*;
#(
    parameter int NUM_TGT = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int SEL_LSB = DEF_SEL_LSB,
    parameter int SEL_W   = DEF_SEL_W,
    parameter int TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      s_psel,
    input  logic                      s_penable,
    input  logic [ADDR_W-1:0]         s_paddr,
    input  logic                      s_pwrite,
    input  logic [DATA_W-1:0]         s_pwdata,
    output logic                      s_pready,
    output logic [DATA_W-1:0]         s_prdata,
    output logic                      s_pslverr,
    output logic [NUM_TGT-1:0]        m_psel,
    output logic                      m_penable,
    output logic [ADDR_W-1:0]         m_paddr,
    output logic                      m_pwrite,
    output logic [DATA_W-1:0]         m_pwdata,
    input  logic [NUM_TGT-1:0]        m_pready,
    input  logic [NUM_TGT*DATA_W-1:0] m_prdata,
    input  logic [NUM_TGT-1:0]        m_pslverr,
    output logic [7:0]                err_count
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT - 1);

    state_e              state_reg;
    logic [SEL_W-1:0]    idx;
    logic                idx_valid;
    logic [NUM_TGT-1:0]  sel_onehot;
    logic [DATA_W-1:0]   masked_rdata [NUM_TGT];
    logic [DATA_W-1:0]   sel_rdata;
    logic                sel_ready;
    logic                sel_err;
    logic                to_expired;

    assign idx       = s_paddr[SEL_LSB +: SEL_W];
    assign idx_valid = (32'(idx) < 32'(NUM_TGT));

    // m_psel is one-hot while a transfer is live, so it doubles as the mask
    // that makes unselected targets' responses invisible.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_TGT; gi++) begin : g_tgt
            assign sel_onehot[gi]   = (32'(idx) == gi);
            assign masked_rdata[gi] = m_psel[gi] ? m_prdata[gi*DATA_W +: DATA_W] : '0;
        end
    endgenerate

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NUM_TGT; i++) begin
            sel_rdata = sel_rdata | masked_rdata[i];
        end
    end

    assign sel_ready = |(m_pready & m_psel);
    assign sel_err   = |(m_pslverr & m_psel);

    apb_timeout_ctr #(
        .WIDTH(CNT_W)
    ) u_timeout_ctr (
        .clk        (clk),
        .rst        (rst),
        .load       (state_reg == ST_M_SETUP),
        .load_value (TIMEOUT_LOAD),
        .dec        (state_reg == ST_M_ACCESS),
        .expired    (to_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            s_pready  <= 1'b0;
            s_prdata  <= '0;
            s_pslverr <= 1'b0;
            m_psel    <= '0;
            m_penable <= 1'b0;
            m_paddr   <= '0;
            m_pwrite  <= 1'b0;
            m_pwdata  <= '0;
            err_count <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    s_pready  <= 1'b0;
                    s_pslverr <= 1'b0;
                    s_prdata  <= '0;
                    if (s_psel && !s_penable) begin
                        m_paddr  <= s_paddr;
                        m_pwrite <= s_pwrite;
                        m_pwdata <= s_pwdata;
                        if (idx_valid) begin
                            m_psel    <= sel_onehot;
                            state_reg <= ST_M_SETUP;
                        end else begin
                            // Response is raised now so it is visible the cycle after setup.
                            s_pready  <= 1'b1;
                            s_pslverr <= 1'b1;
                            err_count <= sat_inc(err_count);
                            state_reg <= ST_DEC_ERR;
                        end
                    end
                end
                ST_M_SETUP: begin
                    m_penable <= 1'b1;
                    state_reg <= ST_M_ACCESS;
                end
                ST_M_ACCESS: begin
                    if (sel_ready) begin
                        m_psel    <= '0;
                        m_penable <= 1'b0;
                        s_pready  <= 1'b1;
                        s_pslverr <= sel_err;
                        s_prdata  <= m_pwrite ? '0 : sel_rdata;
                        state_reg <= ST_RESP;
                    end else if (to_expired) begin
                        m_psel    <= '0;
                        m_penable <= 1'b0;
                        s_pready  <= 1'b1;
                        s_pslverr <= 1'b1;
                        s_prdata  <= '0;
                        err_count <= sat_inc(err_count);
                        state_reg <= ST_RESP;
                    end
                end
                ST_RESP, ST_DEC_ERR: begin
                    s_pready  <= 1'b0;
                    s_pslverr <= 1'b0;
                    s_prdata  <= '0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
